// File: rtl/sdram_init_checker_if.sv
// Init command bus as driven by the controller, plus the checker's status outputs.
interface sdram_init_checker_if;
   logic [19:0] init_bus;
   logic        ready;
   logic        ready_p;
   logic [12:0] mode_reg;
   logic        err;
   logic [2:0]  err_code;

   modport master (output init_bus, input ready, ready_p, mode_reg, err, err_code);
   modport slave  (input init_bus, output ready, ready_p, mode_reg, err, err_code);
endinterface

// File: rtl/sdram_init_checker.sv
// Device-side SDRAM power-up protocol checker: order, spacing, mode capture, first-error report.
// Optional LMR mode-code comparison enabled by defining SDRAM_INIT_CHK_MODE_EN.
module sdram_init_checker #(
   parameter int unsigned T_PWR    = 20000,
   parameter int unsigned T_RP     = 2,
   parameter int unsigned T_RFC    = 7,
   parameter int unsigned T_MRD    = 2,
   parameter int unsigned N_REF    = 2,
   parameter logic [12:0] EXP_MODE = 13'h0032
) (
   input logic                 clk,
   input logic                 rst_n,
   sdram_init_checker_if.slave bus
);

`ifdef SDRAM_INIT_CHK_MODE_EN
   localparam bit MODE_CHK = 1'b1;
`else
   localparam bit MODE_CHK = 1'b0;
`endif

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;

   // gap holds cycles since the last command, so a spacing of T is met at gap == T-1
   localparam logic [15:0] PWR_MIN = 16'(T_PWR - 1);
   localparam logic [15:0] RP_MIN  = 16'(T_RP - 1);
   localparam logic [15:0] RFC_MIN = 16'(T_RFC - 1);
   localparam logic [15:0] MRD_MIN = 16'(T_MRD - 1);
   localparam logic [2:0]  REF_MIN = 3'(N_REF);

   typedef enum logic [2:0] {ST_PWR, ST_RP, ST_RF, ST_MRD, ST_RDY, ST_FAIL} state_t;

   state_t      state_q, state_d;
   logic [15:0] gap_q, gap_d;
   logic [2:0]  ref_cnt_q, ref_cnt_d;
   logic [12:0] mode_q, mode_d;
   logic        ready_q, ready_d;
   logic        ready_p_q, ready_p_d;
   logic        err_q, err_d;
   logic [2:0]  err_code_q, err_code_d;

   logic [3:0]  cmd;
   logic        cke;
   logic [12:0] addr;
   logic [1:0]  ba;
   logic        is_cmd;
   logic        kill;
   logic [2:0]  raise_code;

   assign {cmd, cke, addr, ba} = bus.init_bus;
   assign is_cmd = !cmd[3] && (cmd != CMD_NOP);

   always_comb begin
      state_d    = state_q;
      ref_cnt_d  = ref_cnt_q;
      mode_d     = mode_q;
      ready_p_d  = 1'b0;
      kill       = 1'b0;
      raise_code = '0;
      gap_d      = is_cmd ? '0 : ((gap_q == '1) ? gap_q : gap_q + 16'd1);

      // raise_code is non-zero exactly when an error is seen; kill additionally ends the sequence
      unique case (state_q)
         ST_PWR: begin
            if (is_cmd) begin
               if (cmd == CMD_PRE && addr[10] && cke && gap_q >= PWR_MIN) begin
                  state_d = ST_RP;
               end else begin
                  kill       = 1'b1;
                  raise_code = (gap_q < PWR_MIN) ? 3'd1 : 3'd5;
               end
            end
         end
         ST_RP: begin
            if (is_cmd && gap_q < RP_MIN) begin
               kill = 1'b1; raise_code = 3'd2;
            end else if (!cke) begin
               kill = 1'b1; raise_code = 3'd6;
            end else if (is_cmd) begin
               if (cmd == CMD_REF) begin
                  state_d   = ST_RF;
                  ref_cnt_d = 3'd1;
               end else begin
                  kill = 1'b1; raise_code = 3'd5;
               end
            end
         end
         ST_RF: begin
            if (is_cmd && gap_q < RFC_MIN) begin
               kill = 1'b1; raise_code = 3'd3;
            end else if (!cke) begin
               kill = 1'b1; raise_code = 3'd6;
            end else if (is_cmd) begin
               if (cmd == CMD_REF) begin
                  ref_cnt_d = (ref_cnt_q == 3'd7) ? ref_cnt_q : ref_cnt_q + 3'd1;
               end else if (cmd == CMD_LMR && ref_cnt_q >= REF_MIN && ba == '0) begin
                  mode_d  = addr;
                  state_d = ST_MRD;
                  if (MODE_CHK && addr != EXP_MODE) raise_code = 3'd7;
               end else begin
                  kill = 1'b1; raise_code = 3'd5;
               end
            end
         end
         ST_MRD: begin
            if (is_cmd) begin
               kill = 1'b1; raise_code = 3'd4;
            end else if (!cke) begin
               kill = 1'b1; raise_code = 3'd6;
            end else if (gap_q >= MRD_MIN) begin
               state_d   = ST_RDY;
               ready_p_d = 1'b1;
            end
         end
         default: begin
         end
      endcase

      if (kill) state_d = ST_FAIL;

      ready_d    = (state_d == ST_RDY);
      err_d      = err_q | (raise_code != '0);
      err_code_d = err_q ? err_code_q : raise_code;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_PWR;
         gap_q      <= '0;
         ref_cnt_q  <= '0;
         mode_q     <= '0;
         ready_q    <= 1'b0;
         ready_p_q  <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= '0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         ref_cnt_q  <= ref_cnt_d;
         mode_q     <= mode_d;
         ready_q    <= ready_d;
         ready_p_q  <= ready_p_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.ready_p  = ready_p_q;
   assign bus.mode_reg = mode_q;
   assign bus.err      = err_q;
   assign bus.err_code = err_code_q;

endmodule
